// File: rtl/seq_pkg.sv
// Shared definitions for the systolic array sequencer: FSM encoding and
// the values driven on inst[1] toward the array.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADW   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_t;

    // inst[1]: 1 lets the weight row in WinL pass into the array, 0 holds weights
    localparam logic INST_WPASS = 1'b1;
    localparam logic INST_HOLD  = 1'b0;

endpackage

// File: rtl/seq_result_fifo.sv
// First-word-fall-through result FIFO. Entry = {last, SoutL}.
// A push while full is accepted only when a pop frees a slot in the same cycle;
// otherwise the data is dropped (the sequencer's in-flight limit prevents this).
module seq_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // A result arriving with no room is lost; this should never happen.
    no_overflow_a : assert property (@(posedge clk) disable iff (res)
        !(push && full && !pop));

endmodule

// File: rtl/systolic_sequencer.sv
// Command-driven sequencer for one systolic array: weight load, X streaming,
// bias presentation and result collection into a valid/ready FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready high
// ST_LOADW   | accepting ARRAY_WIDTH weight rows, each passed for one cycle
// ST_COMPUTE | streaming cmd_rows X vectors, throttled by in-flight count
// ST_DRAIN   | all X issued, waiting for remaining results or timeout
// ST_DONE    | one-cycle completion, back to IDLE
module systolic_sequencer
    import seq_pkg::*;
#(
    parameter int ARRAY_LENGTH  = 4,
    parameter int ARRAY_WIDTH   = 4,
    parameter int RES_DEPTH     = 4,
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_width,
    input  logic                        cmd_reload_w,
    input  logic [CNT_W-1:0]            cmd_rows,
    input  logic [ARRAY_LENGTH*32-1:0]  cmd_bias,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [ARRAY_LENGTH*16-1:0]  w_data,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [ARRAY_WIDTH*16-1:0]   x_data,
    output logic [1:0]                  inst,
    output logic [ARRAY_LENGTH*16-1:0]  WinL,
    output logic [ARRAY_WIDTH*16-1:0]   XinL,
    output logic [ARRAY_LENGTH*32-1:0]  BinL,
    input  logic [ARRAY_LENGTH*32-1:0]  SoutL,
    input  logic                        Sready,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [ARRAY_LENGTH*32-1:0]  r_data,
    output logic                        r_last,
    output logic                        busy,
    output logic                        err_timeout
);
    localparam int CW    = $clog2(RES_DEPTH) + 1;
    localparam int WB_W  = $clog2(ARRAY_WIDTH + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int RW    = ARRAY_LENGTH * 32;

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              width_q;
    logic              wpass_q;
    logic [CNT_W-1:0]  rows_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  received_q;
    logic [WB_W-1:0]   wbeat_q;
    logic [CW-1:0]     inflight_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              cmd_fire;
    logic              w_fire;
    logic              x_fire;
    logic              pop;
    logic              res_push;
    logic              tmo_hit;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [RW:0]       fifo_out;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign w_ready     = (state_q == ST_LOADW);
    assign x_ready     = (state_q == ST_COMPUTE) && (inflight_q < CW'(RES_DEPTH))
                         && (issued_q != rows_q);
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign w_fire      = w_valid && w_ready;
    assign x_fire      = x_valid && x_ready;
    assign pop         = r_valid && r_ready;
    assign res_push    = Sready && ((state_q == ST_COMPUTE) || (state_q == ST_DRAIN));
    assign tmo_hit     = (state_q == ST_DRAIN) && !Sready && (tmo_q == '0)
                         && (received_q != rows_q);
    assign inst        = {(wpass_q ? INST_WPASS : INST_HOLD), width_q};

    assign r_valid     = !fifo_empty;
    assign r_data      = r_valid ? fifo_out[RW-1:0] : '0;
    assign r_last      = r_valid && fifo_out[RW];

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_reload_w)          state_d = ST_LOADW;
                    else if (cmd_rows == '0)   state_d = ST_DONE;
                    else                       state_d = ST_COMPUTE;
                end
            end
            ST_LOADW: begin
                if (w_fire && (wbeat_q == WB_W'(ARRAY_WIDTH - 1))) begin
                    state_d = (rows_q == '0) ? ST_DONE : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (x_fire && ((issued_q + CNT_W'(1)) == rows_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (received_q == rows_q || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, command latches, array drive registers and counters.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            width_q     <= 1'b0;
            wpass_q     <= 1'b0;
            rows_q      <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            wbeat_q     <= '0;
            inflight_q  <= '0;
            tmo_q       <= TMO_W'(DRAIN_TIMEOUT - 1);
            err_timeout <= 1'b0;
            WinL        <= '0;
            XinL        <= '0;
            BinL        <= '0;
        end else begin
            state_q <= state_d;
            wpass_q <= w_fire;
            // Bubbles reach the array as zero vectors.
            XinL    <= x_fire ? x_data : '0;

            if (cmd_fire) begin
                width_q     <= cmd_width;
                rows_q      <= cmd_rows;
                BinL        <= cmd_bias;
                issued_q    <= '0;
                received_q  <= '0;
                wbeat_q     <= '0;
                err_timeout <= 1'b0;
            end
            if (w_fire) begin
                WinL    <= w_data;
                wbeat_q <= wbeat_q + WB_W'(1);
            end
            if (x_fire) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (res_push) begin
                received_q <= received_q + CNT_W'(1);
            end

            // Down-counter of Sready-free DRAIN cycles; reloads on every result.
            if (state_q != ST_DRAIN || Sready) begin
                tmo_q <= TMO_W'(DRAIN_TIMEOUT - 1);
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - TMO_W'(1);
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end

            // Results that will never arrive are written off on timeout so the
            // throttle only counts what actually occupies the FIFO.
            if (tmo_hit) begin
                inflight_q <= fifo_count - CW'(pop);
            end else begin
                unique case ({x_fire, pop})
                    2'b10:   inflight_q <= inflight_q + CW'(1);
                    2'b01:   inflight_q <= inflight_q - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    seq_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (RW + 1)
    ) u_res_fifo (
        .clk       (clk),
        .res       (res),
        .push      (res_push),
        .push_data ({(received_q == rows_q - CNT_W'(1)), SoutL}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: a table of commands plus
// hand-written corner sequences, checked against a queue-based array/result model.
module tb_systolic_sequencer;
    localparam int AL = 4;
    localparam int AW = 4;
    localparam int RD = 4;
    localparam int CW = 16;
    localparam int DT = 255;

    logic            clk = 1'b0;
    logic            res = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_width = 1'b0;
    logic            cmd_reload_w = 1'b0;
    logic [CW-1:0]   cmd_rows = '0;
    logic [AL*32-1:0] cmd_bias = '0;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [AL*16-1:0] w_data = '0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [AW*16-1:0] x_data = '0;
    logic [1:0]      inst;
    logic [AL*16-1:0] WinL;
    logic [AW*16-1:0] XinL;
    logic [AL*32-1:0] BinL;
    logic [AL*32-1:0] SoutL = '0;
    logic            Sready = 1'b0;
    logic            r_valid;
    logic            r_ready = 1'b0;
    logic [AL*32-1:0] r_data;
    logic            r_last;
    logic            busy;
    logic            err_timeout;

    systolic_sequencer #(
        .ARRAY_LENGTH(AL), .ARRAY_WIDTH(AW), .RES_DEPTH(RD), .CNT_W(CW), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_width(cmd_width),
        .cmd_reload_w(cmd_reload_w), .cmd_rows(cmd_rows), .cmd_bias(cmd_bias),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .inst(inst), .WinL(WinL), .XinL(XinL), .BinL(BinL),
        .SoutL(SoutL), .Sready(Sready),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [63:0] x;
    } pend_t;

    typedef struct {
        logic [127:0] d;
        logic         last;
    } exp_t;

    typedef struct {
        logic reload;
        logic width;
        int   rows;
        int   lat;
        int   rr_mode;
        int   bubble_pct;
        int   exp_wpass;
        int   exp_results;
    } vec_t;

    pend_t pend_q[$];
    exp_t  exp_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int unsigned cyc = 0;
    int lat      = 6;
    int rr_mode  = 0;   // 0: always ready, 1: random, 2: never
    bit stall    = 1'b0;
    int cur_rows = 0;
    int xrow     = 0;
    int xhs_cnt  = 0;
    int wpass_cnt = 0;
    int rcnt     = 0;

    // The "array": a result per accepted X vector, a fixed latency later.
    function automatic logic [127:0] sout_of(input logic [63:0] x);
        return {x ^ 64'h0123_4567_89AB_CDEF, ~x};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Posedge observer: cycle count, array input capture, scoreboard.
    initial forever begin
        @(posedge clk);
        if (res) begin
            pend_q.delete();
            exp_q.delete();
        end else begin
            if (cmd_valid && cmd_ready) begin
                cur_rows  = int'(cmd_rows);
                xrow      = 0;
                xhs_cnt   = 0;
                wpass_cnt = 0;
                rcnt      = 0;
            end
            if (inst[1]) wpass_cnt++;
            if (x_valid && x_ready) begin
                pend_q.push_back('{cyc + lat, x_data});
                exp_q.push_back('{sout_of(x_data), (xrow == cur_rows - 1)});
                xrow++;
                xhs_cnt++;
            end
            if (r_valid && r_ready) begin
                rcnt++;
                if (exp_q.size() == 0) begin
                    chk("r_unexpected", 128'd1, 128'd0);
                end else begin
                    chk("r_data", r_data, exp_q[0].d);
                    chk("r_last", {127'd0, r_last}, {127'd0, exp_q[0].last});
                    void'(exp_q.pop_front());
                end
            end
        end
        cyc++;
    end

    // Array output, driven from the falling edge.
    initial forever begin
        @(negedge clk);
        if (!res && !stall && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            Sready = 1'b1;
            SoutL  = sout_of(pend_q[0].x);
            void'(pend_q.pop_front());
        end else begin
            Sready = 1'b0;
            SoutL  = '0;
        end
    end

    // Result-side backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        r_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic do_reset();
        res = 1'b1;
        cmd_valid = 1'b0;
        w_valid = 1'b0;
        x_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic send_cmd(input logic reload, input logic width, input int rows,
                            input logic [127:0] bias);
        int t = 0;
        while (!cmd_ready && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_ready_wait", {127'd0, cmd_ready}, 128'd1);
        cmd_valid = 1'b1;
        cmd_reload_w = reload;
        cmd_width = width;
        cmd_rows = CW'(rows);
        cmd_bias = bias;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("cmd_bias", BinL, bias);
        chk("cmd_busy", {127'd0, busy}, 128'd1);
        chk("cmd_err_clr", {127'd0, err_timeout}, 128'd0);
        chk("cmd_width", {127'd0, inst[0]}, {127'd0, width});
    endtask

    task automatic feed_w(input logic [63:0] d);
        int t = 0;
        bit hs = 1'b0;
        w_valid = 1'b1;
        w_data = d;
        do begin
            @(posedge clk);
            hs = w_ready;
            t++;
        end while (!hs && t < 200);
        #1;
        chk("w_handshake", {127'd0, hs}, 128'd1);
        chk("w_winl", {64'd0, WinL}, {64'd0, d});
        chk("w_inst_pass", {127'd0, inst[1]}, 128'd1);
    endtask

    task automatic feed_x(input int n, input int bubble_pct);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            bit hs = 1'b0;
            logic [63:0] d;
            while ($urandom_range(0, 99) < bubble_pct) begin
                x_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            d = {$urandom, $urandom};
            x_valid = 1'b1;
            x_data = d;
            do begin
                @(posedge clk);
                hs = x_ready;
                t++;
            end while (!hs && t < 500);
            #1;
            chk("x_handshake", {127'd0, hs}, 128'd1);
            chk("x_xinl", {64'd0, XinL}, {64'd0, d});
            chk("x_inst_hold", {127'd0, inst[1]}, 128'd0);
        end
        x_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int t = 0;
        while (busy && t < max_cyc) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wait_idle", {127'd0, busy}, 128'd0);
    endtask

    task automatic finish_cmd(input int exp_results, input int exp_wpass);
        int t = 0;
        wait_idle(3000);
        while (exp_q.size() > 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("results_count", 128'(rcnt), 128'(exp_results));
        chk("wpass_cycles", 128'(wpass_cnt), 128'(exp_wpass));
        chk("end_rvalid", {127'd0, r_valid}, 128'd0);
        chk("end_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        chk("end_err", {127'd0, err_timeout}, 128'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int t;
        logic [127:0] bias;

        tbl[0] = '{1'b1, 1'b0, 0, 6, 0, 0, 4, 0};     // weight load only
        tbl[1] = '{1'b1, 1'b1, 8, 6, 0, 0, 4, 8};     // reload + 8 rows, 16-bit
        tbl[2] = '{1'b0, 1'b0, 10, 3, 1, 20, 0, 10};  // random backpressure
        tbl[3] = '{1'b0, 1'b1, 1, 1, 0, 0, 0, 1};     // single row, shortest latency
        tbl[4] = '{1'b0, 1'b0, 0, 6, 0, 0, 0, 0};     // straight to DONE
        tbl[5] = '{1'b1, 1'b0, 5, 10, 1, 40, 4, 5};   // long latency, bubbles
        tbl[6] = '{1'b0, 1'b0, 12, 2, 1, 0, 0, 12};   // FIFO kept near full

        do_reset();
        chk("rst_inst", {126'd0, inst}, 128'd0);
        chk("rst_winl", {64'd0, WinL}, 128'd0);
        chk("rst_xinl", {64'd0, XinL}, 128'd0);
        chk("rst_binl", BinL, 128'd0);
        chk("rst_rvalid", {127'd0, r_valid}, 128'd0);
        chk("rst_rlast", {127'd0, r_last}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err_timeout}, 128'd0);
        chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);

        for (int v = 0; v < 7; v++) begin
            lat = tbl[v].lat;
            rr_mode = tbl[v].rr_mode;
            bias = {$urandom, $urandom, $urandom, $urandom};
            send_cmd(tbl[v].reload, tbl[v].width, tbl[v].rows, bias);
            if (tbl[v].reload) begin
                for (int b = 0; b < AW; b++) begin
                    logic [15:0] lane;
                    lane = 16'h0101 * 16'(b + 1);
                    feed_w({4{lane}});
                end
                w_valid = 1'b0;
            end
            feed_x(tbl[v].rows, tbl[v].bubble_pct);
            finish_cmd(tbl[v].exp_results, tbl[v].exp_wpass);
        end

        // Backpressure: only RES_DEPTH rows may be in flight while r_ready is low.
        lat = 4;
        rr_mode = 2;
        send_cmd(1'b0, 1'b0, 10, 128'h1);
        fork
            feed_x(10, 0);
            begin
                repeat (40) @(posedge clk);
                #2;
                chk("bp_issued", 128'(xhs_cnt), 128'(RD));
                chk("bp_xready", {127'd0, x_ready}, 128'd0);
                chk("bp_rvalid", {127'd0, r_valid}, 128'd1);
                rr_mode = 0;
            end
        join
        finish_cmd(10, 0);

        // Drain timeout: array never answers.
        stall = 1'b1;
        lat = 2;
        send_cmd(1'b0, 1'b0, 2, 128'h2);
        feed_x(2, 0);
        repeat (200) @(posedge clk);
        #1;
        chk("tmo_early_err", {127'd0, err_timeout}, 128'd0);
        chk("tmo_early_busy", {127'd0, busy}, 128'd1);
        wait_idle(100);
        chk("tmo_err", {127'd0, err_timeout}, 128'd1);
        chk("tmo_rvalid", {127'd0, r_valid}, 128'd0);
        pend_q.delete();
        exp_q.delete();
        stall = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("tmo_sticky", {127'd0, err_timeout}, 128'd1);
        send_cmd(1'b0, 1'b0, 0, 128'h3);
        finish_cmd(0, 0);

        // Throttle recovers after a timeout: a full command still runs.
        lat = 3;
        rr_mode = 1;
        send_cmd(1'b0, 1'b1, 6, 128'h4);
        feed_x(6, 10);
        finish_cmd(6, 0);

        // Reset in the middle of COMPUTE after three issues.
        lat = 1;
        rr_mode = 2;
        send_cmd(1'b0, 1'b0, 10, 128'h5);
        x_valid = 1'b1;
        x_data = {$urandom, $urandom};
        t = 0;
        while (xhs_cnt < 3 && t < 100) begin
            @(posedge clk);
            #1;
            x_data = {$urandom, $urandom};
            t++;
        end
        chk("mid_issued", 128'(xhs_cnt), 128'd3);
        chk("mid_rvalid_pre", {127'd0, r_valid}, 128'd1);
        x_valid = 1'b0;
        res = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_busy", {127'd0, busy}, 128'd0);
        chk("mid_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        chk("mid_rvalid", {127'd0, r_valid}, 128'd0);
        chk("mid_inst", {126'd0, inst}, 128'd0);
        chk("mid_xinl", {64'd0, XinL}, 128'd0);
        chk("mid_binl", BinL, 128'd0);
        res = 1'b0;
        rr_mode = 0;

        // Randomized commands.
        for (int k = 0; k < 6; k++) begin
            logic rl;
            int   nr;
            rl = 1'($urandom_range(0, 1));
            nr = int'($urandom_range(1, 12));
            lat = int'($urandom_range(1, 8));
            rr_mode = 1;
            send_cmd(rl, 1'($urandom_range(0, 1)), nr, {$urandom, $urandom, $urandom, $urandom});
            if (rl) begin
                for (int b = 0; b < AW; b++) feed_w({$urandom, $urandom});
                w_valid = 1'b0;
            end
            feed_x(nr, 30);
            finish_cmd(nr, rl ? AW : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
